// File: rtl/axi4_id_remapper.sv
// Wide-to-narrow AXI4 ID remapper: per-direction slot tables restore wide IDs on R/B.
// Optional protocol checker enabled by defining AXI_ID_REMAP_CHECK_EN.

module axi4_id_remap_table #(
    parameter int S_ID_W    = 16,
    parameter int M_ID_W    = 6,
    parameter int NUM_SLOTS = 16,
    parameter int MAX_OUTST = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [S_ID_W-1:0] req_id,
    output logic              req_ready,
    output logic              fwd_valid,
    input  logic              fwd_ready,
    output logic [M_ID_W-1:0] fwd_id,
    input  logic              rsp_valid,
    input  logic [M_ID_W-1:0] rsp_id,
    input  logic              rsp_last,
    input  logic              rsp_ready,
    output logic [S_ID_W-1:0] rsp_orig_id,
    output logic              err
);

    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CNT_W  = $clog2(MAX_OUTST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

    typedef struct packed {
        logic              vld;
        logic [S_ID_W-1:0] id;
        logic [CNT_W-1:0]  cnt;
    } entry_t;

    entry_t tbl [NUM_SLOTS];

    logic              hit;
    logic              free_found;
    logic [SLOT_W-1:0] hit_idx;
    logic [SLOT_W-1:0] free_idx;
    logic [SLOT_W-1:0] sel_idx;
    logic              ok;
    logic              req_fire;
    logic [31:0]       rsp_id_ext;
    logic              rsp_in_range;
    logic [SLOT_W-1:0] rsp_idx;
    entry_t            rsp_entry;
    logic              rsp_live;
    logic              rel_fire;
    logic              rel_ok;
    logic [NUM_SLOTS-1:0] inc_vec;
    logic [NUM_SLOTS-1:0] dec_vec;

    // Descending scan so the lowest matching / free slot wins.
    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (tbl[i].vld && tbl[i].id == req_id) begin
                hit     = 1'b1;
                hit_idx = SLOT_W'(i);
            end
            if (!tbl[i].vld) begin
                free_found = 1'b1;
                free_idx   = SLOT_W'(i);
            end
        end
    end

    assign sel_idx   = hit ? hit_idx : free_idx;
    assign ok        = hit ? (tbl[hit_idx].cnt < MAX_CNT) : free_found;
    assign fwd_valid = req_valid & ok;
    assign req_ready = fwd_ready & ok;
    assign fwd_id    = M_ID_W'(sel_idx);
    assign req_fire  = req_valid & fwd_ready & ok;

    assign rsp_id_ext   = 32'(rsp_id);
    assign rsp_in_range = rsp_id_ext < 32'(NUM_SLOTS);
    assign rsp_idx      = rsp_id[SLOT_W-1:0];
    assign rsp_entry    = rsp_in_range ? tbl[rsp_idx] : '0;
    assign rsp_live     = rsp_in_range & rsp_entry.vld & (rsp_entry.cnt != '0);
    assign rsp_orig_id  = rsp_live ? rsp_entry.id : '0;
    assign rel_fire     = rsp_valid & rsp_ready & rsp_last;
    assign rel_ok       = rel_fire & rsp_live;

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            inc_vec[i] = req_fire && (sel_idx == SLOT_W'(i));
            dec_vec[i] = rel_ok && (rsp_idx == SLOT_W'(i));
        end
    end

    // Simultaneous allocate and release on one slot cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                tbl[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (inc_vec[i] && !dec_vec[i]) begin
                    if (hit) begin
                        tbl[i].cnt <= tbl[i].cnt + CNT_W'(1);
                    end else begin
                        tbl[i].vld <= 1'b1;
                        tbl[i].id  <= req_id;
                        tbl[i].cnt <= CNT_W'(1);
                    end
                end else if (dec_vec[i] && !inc_vec[i]) begin
                    tbl[i].cnt <= tbl[i].cnt - CNT_W'(1);
                    if (tbl[i].cnt == CNT_W'(1)) begin
                        tbl[i].vld <= 1'b0;
                    end
                end
            end
        end
    end

`ifdef AXI_ID_REMAP_CHECK_EN
    logic pend_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= 1'b0;
            err    <= 1'b0;
        end else begin
            pend_q <= req_valid & ~req_ready;
            if ((rel_fire & ~rsp_live) | (pend_q & ~req_valid)) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

module axi4_id_remapper #(
    parameter int S_ID_W    = 16,
    parameter int M_ID_W    = 6,
    parameter int NUM_SLOTS = 16,
    parameter int MAX_OUTST = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_arvalid,
    output logic              s_arready,
    input  logic [S_ID_W-1:0] s_arid,
    output logic              m_arvalid,
    input  logic              m_arready,
    output logic [M_ID_W-1:0] m_arid,
    input  logic              m_rvalid,
    output logic              m_rready,
    input  logic [M_ID_W-1:0] m_rid,
    input  logic              m_rlast,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [S_ID_W-1:0] s_rid,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [S_ID_W-1:0] s_awid,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [M_ID_W-1:0] m_awid,
    input  logic              m_bvalid,
    output logic              m_bready,
    input  logic [M_ID_W-1:0] m_bid,
    output logic              s_bvalid,
    input  logic              s_bready,
    output logic [S_ID_W-1:0] s_bid,
    output logic              err
);

    logic rd_err;
    logic wr_err;

    axi4_id_remap_table #(
        .S_ID_W(S_ID_W), .M_ID_W(M_ID_W),
        .NUM_SLOTS(NUM_SLOTS), .MAX_OUTST(MAX_OUTST)
    ) u_rd (
        .clk(clk), .rst(rst),
        .req_valid(s_arvalid), .req_id(s_arid), .req_ready(s_arready),
        .fwd_valid(m_arvalid), .fwd_ready(m_arready), .fwd_id(m_arid),
        .rsp_valid(m_rvalid), .rsp_id(m_rid), .rsp_last(m_rlast),
        .rsp_ready(s_rready), .rsp_orig_id(s_rid), .err(rd_err)
    );

    axi4_id_remap_table #(
        .S_ID_W(S_ID_W), .M_ID_W(M_ID_W),
        .NUM_SLOTS(NUM_SLOTS), .MAX_OUTST(MAX_OUTST)
    ) u_wr (
        .clk(clk), .rst(rst),
        .req_valid(s_awvalid), .req_id(s_awid), .req_ready(s_awready),
        .fwd_valid(m_awvalid), .fwd_ready(m_awready), .fwd_id(m_awid),
        .rsp_valid(m_bvalid), .rsp_id(m_bid), .rsp_last(1'b1),
        .rsp_ready(s_bready), .rsp_orig_id(s_bid), .err(wr_err)
    );

    assign s_rvalid = m_rvalid;
    assign m_rready = s_rready;
    assign s_bvalid = m_bvalid;
    assign m_bready = s_bready;
    assign err      = rd_err | wr_err;

endmodule

// File: tb/tb_axi4_id_remapper.sv
// Scoreboard bench for axi4_id_remapper: drivers push expected IDs, a negedge monitor checks.
// Expected err level follows AXI_ID_REMAP_CHECK_EN.

module tb_axi4_id_remapper;

    localparam int S_ID_W    = 16;
    localparam int M_ID_W    = 6;
    localparam int NUM_SLOTS = 16;
    localparam int MAX_OUTST = 8;
`ifdef AXI_ID_REMAP_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              s_arvalid = 1'b0, s_arready;
    logic [S_ID_W-1:0] s_arid = '0;
    logic              m_arvalid, m_arready = 1'b1;
    logic [M_ID_W-1:0] m_arid;
    logic              m_rvalid = 1'b0, m_rready, m_rlast = 1'b0;
    logic [M_ID_W-1:0] m_rid = '0;
    logic              s_rvalid, s_rready = 1'b1;
    logic [S_ID_W-1:0] s_rid;
    logic              s_awvalid = 1'b0, s_awready;
    logic [S_ID_W-1:0] s_awid = '0;
    logic              m_awvalid, m_awready = 1'b1;
    logic [M_ID_W-1:0] m_awid;
    logic              m_bvalid = 1'b0, m_bready;
    logic [M_ID_W-1:0] m_bid = '0;
    logic              s_bvalid, s_bready = 1'b1;
    logic [S_ID_W-1:0] s_bid;
    logic              err;

    axi4_id_remapper #(
        .S_ID_W(S_ID_W), .M_ID_W(M_ID_W),
        .NUM_SLOTS(NUM_SLOTS), .MAX_OUTST(MAX_OUTST)
    ) dut (
        .clk(clk), .rst(rst),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid),
        .m_rlast(m_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid),
        .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [M_ID_W-1:0] ar_q [$];
    logic [M_ID_W-1:0] aw_q [$];
    logic [S_ID_W-1:0] r_q  [$];
    logic [S_ID_W-1:0] b_q  [$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every output handshake consumes one expected entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_arvalid && m_arready) begin
                check("ar_expected", 32'(ar_q.size() != 0), 1);
                if (ar_q.size() != 0) check("m_arid", 32'(m_arid), 32'(ar_q.pop_front()));
            end
            if (m_awvalid && m_awready) begin
                check("aw_expected", 32'(aw_q.size() != 0), 1);
                if (aw_q.size() != 0) check("m_awid", 32'(m_awid), 32'(aw_q.pop_front()));
            end
            if (s_rvalid && s_rready) begin
                check("r_expected", 32'(r_q.size() != 0), 1);
                if (r_q.size() != 0) check("s_rid", 32'(s_rid), 32'(r_q.pop_front()));
            end
            if (s_bvalid && s_bready) begin
                check("b_expected", 32'(b_q.size() != 0), 1);
                if (b_q.size() != 0) check("s_bid", 32'(s_bid), 32'(b_q.pop_front()));
            end
        end
    end

    task automatic ar_req(input logic [S_ID_W-1:0] id, input logic [M_ID_W-1:0] slot);
        int n = 0;
        ar_q.push_back(slot);
        @(posedge clk); #1;
        s_arvalid = 1'b1;
        s_arid    = id;
        @(negedge clk);
        while (!s_arready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!s_arready) begin
            check("ar_timeout", 32'(s_arready), 1);
            void'(ar_q.pop_back());
        end
    endtask

    task automatic ar_idle();
        @(posedge clk); #1;
        s_arvalid = 1'b0;
    endtask

    task automatic aw_req(input logic [S_ID_W-1:0] id, input logic [M_ID_W-1:0] slot);
        int n = 0;
        aw_q.push_back(slot);
        @(posedge clk); #1;
        s_awvalid = 1'b1;
        s_awid    = id;
        @(negedge clk);
        while (!s_awready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!s_awready) begin
            check("aw_timeout", 32'(s_awready), 1);
            void'(aw_q.pop_back());
        end
    endtask

    task automatic aw_idle();
        @(posedge clk); #1;
        s_awvalid = 1'b0;
    endtask

    task automatic r_rsp(input logic [M_ID_W-1:0] rid, input logic last,
                         input logic [S_ID_W-1:0] exp);
        r_q.push_back(exp);
        @(posedge clk); #1;
        m_rvalid = 1'b1;
        m_rid    = rid;
        m_rlast  = last;
        @(negedge clk);
    endtask

    task automatic r_idle();
        @(posedge clk); #1;
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
    endtask

    task automatic b_rsp(input logic [M_ID_W-1:0] bid, input logic [S_ID_W-1:0] exp);
        b_q.push_back(exp);
        @(posedge clk); #1;
        m_bvalid = 1'b1;
        m_bid    = bid;
        @(negedge clk);
    endtask

    task automatic b_idle();
        @(posedge clk); #1;
        m_bvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_m_arvalid", 32'(m_arvalid), 0);
        check("rst_m_awvalid", 32'(m_awvalid), 0);
        check("rst_s_rvalid", 32'(s_rvalid), 0);
        check("rst_s_bvalid", 32'(s_bvalid), 0);
        check("rst_err", 32'(err), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic allocate / restore / free
        ar_req(16'h1234, 0);
        ar_idle();
        r_rsp(0, 1'b1, 16'h1234);
        r_idle();
        ar_req(16'h5555, 0);
        ar_idle();
        r_rsp(0, 1'b1, 16'h5555);
        r_idle();

        // Same ID reuses its slot; multi-beat burst frees only on last
        ar_req(16'h000A, 0);
        ar_req(16'h000B, 1);
        ar_req(16'h000A, 0);
        ar_idle();
        check("b_path_idle_bvalid", 32'(s_bvalid), 0);
        check("b_path_idle_awvalid", 32'(m_awvalid), 0);
        r_rsp(0, 1'b1, 16'h000A);
        r_rsp(0, 1'b1, 16'h000A);
        r_rsp(1, 1'b0, 16'h000B);
        r_rsp(1, 1'b1, 16'h000B);
        r_idle();

        // Full table stalls; freed slot usable the cycle after release
        for (int i = 0; i < NUM_SLOTS; i++) ar_req(16'h0100 + 16'(i), M_ID_W'(i));
        ar_idle();
        fork
            ar_req(16'h0200, 5);
            begin
                @(posedge clk);
                @(negedge clk);
                check("full_stall", 32'(s_arready), 0);
                check("full_no_valid", 32'(m_arvalid), 0);
                r_rsp(5, 1'b1, 16'h0105);
                check("freed_not_same_cycle", 32'(s_arready), 0);
                r_idle();
            end
        join
        ar_idle();
        for (int i = 0; i < NUM_SLOTS; i++)
            r_rsp(M_ID_W'(i), 1'b1, (i == 5) ? 16'h0200 : 16'h0100 + 16'(i));
        r_idle();

        // Per-slot outstanding saturation
        for (int i = 0; i < MAX_OUTST; i++) ar_req(16'h0077, 0);
        fork
            ar_req(16'h0077, 0);
            begin
                @(posedge clk);
                @(negedge clk);
                check("cnt_sat_stall", 32'(s_arready), 0);
                r_rsp(0, 1'b1, 16'h0077);
                r_idle();
            end
        join
        ar_idle();
        r_rsp(0, 1'b1, 16'h0077);
        r_idle();
        fork
            ar_req(16'h0077, 0);
            r_rsp(0, 1'b1, 16'h0077);
        join
        fork
            ar_idle();
            r_idle();
        join
        fork
            ar_req(16'h0077, 0);
            begin
                @(posedge clk);
                @(negedge clk);
                check("same_cycle_cnt_kept", 32'(s_arready), 1);
            end
        join
        ar_idle();
        fork
            ar_req(16'h0077, 0);
            begin
                @(posedge clk);
                @(negedge clk);
                check("cnt_sat_again", 32'(s_arready), 0);
                r_rsp(0, 1'b1, 16'h0077);
                r_idle();
            end
        join
        ar_idle();
        for (int i = 0; i < MAX_OUTST; i++) r_rsp(0, 1'b1, 16'h0077);
        r_idle();
        ar_req(16'h0088, 0);
        ar_idle();
        r_rsp(0, 1'b1, 16'h0088);
        r_idle();

        // AW held under backpressure; table only changes on handshake
        m_awready = 1'b0;
        fork
            aw_req(16'hFFFF, 0);
            begin
                @(posedge clk);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("aw_hold_valid", 32'(m_awvalid), 1);
                    check("aw_hold_ready", 32'(s_awready), 0);
                    check("aw_hold_id", 32'(m_awid), 0);
                end
                @(posedge clk); #1;
                m_awready = 1'b1;
            end
        join
        aw_idle();
        b_rsp(0, 16'hFFFF);
        b_idle();
        aw_req(16'h2222, 0);
        aw_idle();
        b_rsp(0, 16'h2222);
        b_idle();

        // Bad releases: forwarded with zero ID, flagged when checking
        check("err_clean", 32'(err), 0);
        b_rsp(5, 16'h0000);
        check("bad_b_forwarded", 32'(s_bvalid), 1);
        b_idle();
        check("err_bad_b", 32'(err), 32'(EXP_ERR));
        r_rsp(20, 1'b1, 16'h0000);
        r_idle();
        check("err_sticky", 32'(err), 32'(EXP_ERR));

        // Reset mid-operation clears table; late response sees empty slot
        ar_req(16'h0042, 0);
        ar_idle();
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_err", 32'(err), 0);
        check("midrst_arvalid", 32'(m_arvalid), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        r_rsp(0, 1'b1, 16'h0000);
        r_idle();
        ar_req(16'h0099, 0);
        ar_idle();
        r_rsp(0, 1'b1, 16'h0099);
        r_idle();

        repeat (2) @(negedge clk);
        check("ar_q_drained", 32'(ar_q.size()), 0);
        check("aw_q_drained", 32'(aw_q.size()), 0);
        check("r_q_drained", 32'(r_q.size()), 0);
        check("b_q_drained", 32'(b_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
